ds_capture_buffer: RTL and testbench
====================================

// Module: ds_capture_buffer
// PURPOSE
//  Snapshot buffer downstream of the decimation chain. Captures a burst of decimated
//  I/Q pairs (downsampled_data_x/y, strobed by ce_down) into block RAM for CPU readout
//  over CSR. Supports arm/trigger/done sequencing with immediate or level-crossing trigger.
// PARAMETERS
//  DW        16  sample width, signed two's complement
//  AW        10  RAM address width; DEPTH = 2**AW sample pairs
// PORTS
//  sys_clk      in   1      system clock (single domain)
//  rst          in   1      asynchronous reset, active-high
//  sample_x     in   DW     decimated I sample, signed
//  sample_y     in   DW     decimated Q sample, signed
//  sample_ce    in   1      1-cycle strobe: sample_x/y valid (ce_down)
//  arm          in   1      1-cycle pulse: start a capture
//  abort        in   1      1-cycle pulse: cancel, return to IDLE
//  trig_mode    in   1      0 = immediate, 1 = rising crossing of sample_x through trig_level
//  trig_level   in   DW     trigger threshold, signed
//  capture_len  in   AW+1   requested pair count; 0 or >DEPTH means DEPTH
//  armed        out  1      state == ARMED
//  busy         out  1      state == ARMED or CAPTURE
//  done         out  1      sticky; set on capture complete, cleared by arm/abort
//  wr_count     out  AW+1   pairs written in current/last capture
//  rd_addr      in   AW     CPU read address
//  rd_data      out  2*DW   {x,y} at rd_addr; x in upper half
// BEHAVIOUR
//  Reset: state=IDLE; armed=busy=done=0; wr_count=0; rd_data=0; prev_valid=0. RAM not cleared.
//  States: IDLE -> ARMED -> CAPTURE -> DONE.
//  - IDLE/DONE: arm -> ARMED; latch len_q = clamp(capture_len); wr_count<=0; done<=0; prev_valid<=0.
//  - ARMED, trig_mode=0: first sample_ce is the trigger sample.
//  - ARMED, trig_mode=1: on sample_ce, trigger when prev_valid && prev_x < trig_level
//    && sample_x >= trig_level (signed compare). prev_x<=sample_x, prev_valid<=1 on every
//    sample_ce in ARMED. The first sample after arm can never trigger.
//  - Trigger sample is written at address 0, wr_count<=1, state -> CAPTURE
//    (-> DONE directly if len_q==1).
//  - CAPTURE: each sample_ce writes {sample_x,sample_y} at addr wr_count[AW-1:0], wr_count++.
//    When the write makes wr_count==len_q: state -> DONE, done<=1 in the same edge.
//  - trig_mode/trig_level are sampled live while ARMED; capture_len only at arm.
//  - arm while ARMED or CAPTURE: ignored. arm in DONE: re-arms (done cleared).
//  - abort (any state) -> IDLE, done<=0, wr_count held. abort and arm same cycle: abort wins.
//  - sample_ce without ARMED/CAPTURE: ignored; no RAM write.
//  - wr_count saturates at len_q; never wraps. Full len_q = DEPTH gives wr_count = 2**AW.
//  - Read port: registered, 1-cycle latency (rd_data valid the cycle after rd_addr).
//    Reads are allowed in any state. Read-during-write to the same address returns OLD data.
//  - Reset asserted mid-capture: immediate return to the reset values above; RAM contents
//    are undefined from the CPU's point of view.
//  - Latency: sample_ce edge -> RAM write on the same edge; wr_count/done update on that edge.
// STRUCTURE
//  - Shared package / include (uc_capture_pkg): state encodings ST_IDLE=0, ST_ARMED=1,
//    ST_CAPTURE=2, ST_DONE=3; default DW/AW localparams; TRIG_IMMEDIATE/TRIG_RISING codes.
//  - Sub-module capture_ram: simple dual-port, 1 write / 1 registered read,
//    width 2*DW, depth 2**AW, infers BRAM, no reset on the array.
//  - Top: FSM, trigger comparator with prev_x register, write address counter, len clamp.
// TESTING
//  1 Reset then idle: pulse sample_ce x50 without arm -> wr_count=0, done=0, busy=0;
//    rd_data=0 until the first read.
//  2 Immediate trigger: capture_len=8, arm, x=1..20 on successive strobes
//    -> done after the 8th strobe; RAM[0..7].x = 1..8; wr_count=8; busy=0.
//  3 Rising trigger: level=100; x = 50,90,120,80,150,... -> capture starts at the 120 sample
//    (RAM[0].x=120). Repeat with first post-arm sample=200 -> no trigger on that sample.
//  4 Boundary length: capture_len=0 and capture_len=2**AW+5 -> both capture exactly 2**AW
//    pairs; wr_count=2**AW; no address wrap overwrites RAM[0].
//  5 Abort/arm collision: arm+abort in the same cycle from IDLE -> stays IDLE. Abort mid-CAPTURE
//    at wr_count=3 -> IDLE, done=0, wr_count=3. Arm during CAPTURE -> ignored.
//  6 Readout: after capture, sweep rd_addr 0..N-1 -> rd_data matches {x,y} one cycle later.
//    Read addr k while writing addr k -> previous contents returned.

Source files
------------

// File: rtl/ds_capture_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ds_capture_buffer_pkg
//  Description : Shared constants, state codes and helpers for the decimated
//                I/Q snapshot capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ds_capture_buffer_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 10;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic TRIG_IMMEDIATE = 1'b0;
    localparam logic TRIG_RISING    = 1'b1;

    // Operands arrive sign-extended to 32 bits so one helper serves any DW <= 32.
    function automatic logic rising_cross(input logic signed [31:0] prev,
                                          input logic signed [31:0] cur,
                                          input logic signed [31:0] lvl);
        return (prev < lvl) && (cur >= lvl);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ds_capture_buffer_if
//  Description : Sample stream, control, status and CPU read-port bundle for
//                the snapshot capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ds_capture_buffer_if
    import ds_capture_buffer_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic [DW-1:0]   sample_x;
    logic [DW-1:0]   sample_y;
    logic            sample_ce;
    logic            arm;
    logic            abort;
    logic            trig_mode;
    logic [DW-1:0]   trig_level;
    logic [AW:0]     capture_len;
    logic            armed;
    logic            busy;
    logic            done;
    logic [AW:0]     wr_count;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_data;

    modport master (
        output sample_x, sample_y, sample_ce, arm, abort,
               trig_mode, trig_level, capture_len, rd_addr,
        input  armed, busy, done, wr_count, rd_data
    );

    modport slave (
        input  sample_x, sample_y, sample_ce, arm, abort,
               trig_mode, trig_level, capture_len, rd_addr,
        output armed, busy, done, wr_count, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/ds_capture_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port; read-during-write returns the previous contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ram
    import ds_capture_buffer_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DW,
    parameter int AW    = DEF_AW
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             we,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic [AW-1:0]    raddr,
    output logic      [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [0:(2**AW)-1];

    // Array kept out of any reset path so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ds_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ds_capture_buffer
//  Description : Arm/trigger/done snapshot of decimated I/Q pairs into block
//                RAM, with immediate or rising level-crossing trigger.
//  Revision    : 1.0 - initial release
// ============================================================================
module ds_capture_buffer
    import ds_capture_buffer_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  wire logic          sys_clk,
    input  wire logic          rst,
    ds_capture_buffer_if.slave bus
);

    localparam logic [AW:0] c_depth = (AW+1)'(2**AW);
    localparam logic [AW:0] c_one   = (AW+1)'(1);

    state_t          r_state;
    logic [AW:0]     r_len;
    logic [AW:0]     r_wr_count;
    logic            r_done;
    logic            r_prev_valid;
    logic [DW-1:0]   r_prev_x;

    logic [AW:0]     w_len_clamp;
    logic            w_cross;
    logic            w_trig;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [AW:0]     w_wr_next;

    assign w_len_clamp = ((bus.capture_len == '0) || (bus.capture_len > c_depth))
                         ? c_depth : bus.capture_len;

    assign w_cross = r_prev_valid &&
                     rising_cross(32'($signed(r_prev_x)),
                                  32'($signed(bus.sample_x)),
                                  32'($signed(bus.trig_level)));

    assign w_trig    = (bus.trig_mode == TRIG_RISING) ? w_cross : 1'b1;
    assign w_wr_next = r_wr_count + c_one;

    // Abort wins over a coincident strobe, so that sample is never written.
    assign w_we = bus.sample_ce && !bus.abort &&
                  (((r_state == ST_ARMED) && w_trig) || (r_state == ST_CAPTURE));

    // wr_count < len_q <= DEPTH in CAPTURE, so the low AW bits never wrap.
    assign w_waddr = (r_state == ST_ARMED) ? '0 : r_wr_count[AW-1:0];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= c_depth;
            r_wr_count   <= '0;
            r_done       <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_x     <= '0;
        end else if (bus.abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.arm) begin
                        r_state      <= ST_ARMED;
                        r_len        <= w_len_clamp;
                        r_wr_count   <= '0;
                        r_done       <= 1'b0;
                        r_prev_valid <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (bus.sample_ce) begin
                        r_prev_x     <= bus.sample_x;
                        r_prev_valid <= 1'b1;
                        if (w_trig) begin
                            r_wr_count <= c_one;
                            if (r_len == c_one) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_CAPTURE;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.sample_ce) begin
                        r_wr_count <= w_wr_next;
                        if (w_wr_next == r_len) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.armed    = (r_state == ST_ARMED);
    assign bus.busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign bus.done     = r_done;
    assign bus.wr_count = r_wr_count;

    capture_ram #(
        .WIDTH (2*DW),
        .AW    (AW)
    ) u_ram (
        .clk   (sys_clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata ({bus.sample_x, bus.sample_y}),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_ds_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ds_capture_buffer
//  Description : Scoreboard bench for ds_capture_buffer: directed stimulus
//                queues expectations, a monitor compares status and readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ds_capture_buffer;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ds_capture_buffer_if #(.DW(DW), .AW(AW)) bus ();

    ds_capture_buffer #(.DW(DW), .AW(AW)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    logic [2*DW-1:0] rd_q [$];
    string           rd_name_q [$];
    logic [13:0]     st_q [$];
    string           st_name_q [$];

    logic rd_req   = 1'b0;
    logic rd_pend  = 1'b0;
    logic stat_req = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] pair(input logic [15:0] x);
        return {x, x ^ 16'h5A5A};
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h, no expectation queued", bus.rd_data);
            end else begin
                logic [31:0] e;
                string nm;
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_fail++;
                    $display("FAIL %s: rd_data got %h, want %h", nm, bus.rd_data, e);
                end
            end
        end
        if (stat_req) begin
            logic [13:0] a;
            a = {bus.busy, bus.done, bus.armed, bus.wr_count};
            n_tests++;
            if (st_q.size() == 0) begin
                n_fail++;
                $display("FAIL st_unexpected: got %h, no expectation queued", a);
            end else begin
                logic [13:0] e;
                string nm;
                e  = st_q.pop_front();
                nm = st_name_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: {busy,done,armed,wr_count} got %b/%b/%b/%0d, want %b/%b/%b/%0d",
                             nm, a[13], a[12], a[11], a[10:0], e[13], e[12], e[11], e[10:0]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.sample_ce = 1'b0;
        rd_req        = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] x);
        bus.sample_x  = x;
        bus.sample_y  = x ^ 16'h5A5A;
        bus.sample_ce = 1'b1;
        tick();
    endtask

    task automatic do_arm(input logic [AW:0] len, input logic mode, input logic [15:0] lvl);
        bus.capture_len = len;
        bus.trig_mode   = mode;
        bus.trig_level  = lvl;
        bus.arm         = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp, input string nm);
        bus.rd_addr = addr;
        rd_req      = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back(nm);
        tick();
    endtask

    task automatic st(input logic b, input logic d, input logic a,
                      input logic [AW:0] wc, input string nm);
        st_q.push_back({b, d, a, wc});
        st_name_q.push_back(nm);
        stat_req = 1'b1;
        @(negedge clk);
        #1;
        stat_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.sample_x = '0; bus.sample_y = '0; bus.sample_ce = 1'b0;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.trig_mode = 1'b0;
        bus.trig_level = '0; bus.capture_len = '0; bus.rd_addr = '0;

        tick();
        rd(10'd0, 32'h0, "rd_during_reset");
        st(0, 0, 0, 11'd0, "reset_status");
        rst = 1'b0;
        tick();

        // 1: strobes without arm are ignored
        for (int i = 0; i < 50; i++) strobe(16'hDEAD);
        st(0, 0, 0, 11'd0, "t1_idle_strobes");

        // 2: immediate trigger, len 8
        do_arm(11'd8, 1'b0, 16'd0);
        st(1, 0, 1, 11'd0, "t2_armed");
        for (int i = 1; i <= 3; i++) strobe(16'(i));
        st(1, 0, 0, 11'd3, "t2_mid");
        for (int i = 4; i <= 8; i++) strobe(16'(i));
        st(0, 1, 0, 11'd8, "t2_done");
        for (int i = 9; i <= 20; i++) strobe(16'(i));
        st(0, 1, 0, 11'd8, "t2_saturate");
        for (int k = 0; k < 8; k++) rd(10'(k), pair(16'(k + 1)), "t2_read");

        // 3: rising trigger
        do_arm(11'd4, 1'b1, 16'd100);
        strobe(16'd50); strobe(16'd90);
        st(1, 0, 1, 11'd0, "t3_no_trig_yet");
        strobe(16'd120);
        st(1, 0, 0, 11'd1, "t3_triggered");
        strobe(16'd80); strobe(16'd150); strobe(16'd160);
        st(0, 1, 0, 11'd4, "t3_done");
        rd(10'd0, pair(16'd120), "t3_ram0");
        rd(10'd1, pair(16'd80),  "t3_ram1");
        rd(10'd3, pair(16'd160), "t3_ram3");

        do_arm(11'd4, 1'b1, 16'd200);
        strobe(16'd200);
        st(1, 0, 1, 11'd0, "t3b_first_no_trig");
        strobe(16'd150); strobe(16'd210); strobe(16'd10); strobe(16'd20); strobe(16'd30);
        st(0, 1, 0, 11'd4, "t3b_done");
        rd(10'd0, pair(16'd210), "t3b_ram0");
        rd(10'd3, pair(16'd30),  "t3b_ram3");

        do_arm(11'd1, 1'b1, 16'd0);
        strobe(16'hFFEC); strobe(16'hFFFB);
        st(1, 0, 1, 11'd0, "t3c_signed_no_trig");
        strobe(16'd5);
        st(0, 1, 0, 11'd1, "t3c_len1_done");
        rd(10'd0, pair(16'd5),  "t3c_ram0");
        rd(10'd1, pair(16'd10), "t3c_no_extra_write");

        // 4: boundary lengths
        do_arm(11'd0, 1'b0, 16'd0);
        for (int k = 0; k < 1030; k++) strobe(16'h2000 + 16'(k));
        st(0, 1, 0, 11'd1024, "t4_len0");
        rd(10'd0,    pair(16'h2000), "t4_len0_ram0");
        rd(10'd5,    pair(16'h2005), "t4_len0_ram5");
        rd(10'd1023, pair(16'h23FF), "t4_len0_ram1023");

        do_arm(11'd1029, 1'b0, 16'd0);
        for (int k = 0; k < 1023; k++) strobe(16'h4000 + 16'(k));
        st(1, 0, 0, 11'd1023, "t4_almost_full");
        for (int k = 1023; k < 1030; k++) strobe(16'h4000 + 16'(k));
        st(0, 1, 0, 11'd1024, "t4_len_over");
        rd(10'd0,    pair(16'h4000), "t4_over_ram0");
        rd(10'd1023, pair(16'h43FF), "t4_over_ram1023");

        // 5: abort / arm collisions
        bus.abort = 1'b1;
        tick();
        st(0, 0, 0, 11'd1024, "t5_abort_from_done");
        bus.capture_len = 11'd8;
        bus.arm = 1'b1; bus.abort = 1'b1;
        tick();
        st(0, 0, 0, 11'd1024, "t5_arm_abort_same_cycle");
        do_arm(11'd8, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) strobe(16'h0700 + 16'(k));
        st(1, 0, 0, 11'd3, "t5_capture_3");
        bus.capture_len = 11'd2;
        bus.arm = 1'b1;
        tick();
        st(1, 0, 0, 11'd3, "t5_arm_in_capture");
        bus.abort = 1'b1;
        tick();
        st(0, 0, 0, 11'd3, "t5_abort_mid");
        for (int k = 0; k < 3; k++) strobe(16'hDEAD);
        st(0, 0, 0, 11'd3, "t5_idle_after_abort");
        rd(10'd3, pair(16'h4003), "t5_no_idle_write");

        // 6: readout and read-during-write
        do_arm(11'd4, 1'b0, 16'd0);
        strobe(16'h0900);
        bus.sample_x = 16'h0901; bus.sample_y = 16'h0901 ^ 16'h5A5A; bus.sample_ce = 1'b1;
        rd(10'd1, pair(16'h0701), "t6_read_during_write");
        strobe(16'h0902); strobe(16'h0903);
        st(0, 1, 0, 11'd4, "t6_done");
        for (int k = 0; k < 4; k++) rd(10'(k), pair(16'h0900 + 16'(k)), "t6_sweep");
        rd(10'd4, pair(16'h4004), "t6_beyond_len");

        tick(); tick(); tick();
        n_tests++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", rd_q.size(), st_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
